// File: rtl/pwl_chaos_rng.sv
// Piecewise-linear jerk-chaos random word generator.
// Three coupled fixed-point integrators with warm-up and valid/ready output.
module pwl_chaos_rng #(
    parameter int               Width   = 16,
    parameter int               Frac    = 13,
    parameter int               HShift  = 6,
    parameter logic [Width-1:0] ACoef   = 16'h1000,
    parameter int               Discard = 16,
    parameter int               OutW    = 8,
    parameter logic [Width-1:0] X0      = '0,
    parameter logic [Width-1:0] Y0      = '0,
    parameter logic [Width-1:0] Z0      = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            seed_we_i,
    input  logic [Width-1:0] seed_x_i,
    input  logic [Width-1:0] seed_y_i,
    input  logic [Width-1:0] seed_z_i,
    output logic [OutW-1:0] rand_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            busy_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WARMUP = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic signed [Width-1:0] ONE =
        {{(Width-1){1'b0}}, 1'b1} << Frac;

    logic [1:0] state;
    logic [7:0] wcnt;
    logic       start_q;

    logic signed [Width-1:0] x, y, z;
    logic signed [Width-1:0] sx, sy, sz;
    logic signed [Width-1:0] x_n, y_n, z_n;
    logic signed [Width-1:0] abs_x, az, dz;
    logic signed [2*Width-1:0] prod;
    logic [OutW-1:0] rand_n;

    always_comb begin
        abs_x  = x[Width-1] ? -x : x;
        prod   = $signed(ACoef) * z;
        az     = prod[Frac +: Width];
        dz     = abs_x - ONE - y - az;
        x_n    = x + (y >>> HShift);
        y_n    = y + (z >>> HShift);
        z_n    = z + (dz >>> HShift);
        rand_n = x_n[OutW-1:0] ^ y_n[OutW-1:0] ^ z_n[OutW-1:0];
    end

    assign busy_o = (state != IDLE);

    // start is registered so a seed write in the same cycle is what gets loaded
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            wcnt    <= '0;
            start_q <= 1'b0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            sx      <= X0;
            sy      <= Y0;
            sz      <= Z0;
            rand_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            start_q <= start_i & (state == IDLE) & ~start_q;
            unique case (state)
                IDLE: begin
                    if (seed_we_i) begin
                        sx <= seed_x_i;
                        sy <= seed_y_i;
                        sz <= seed_z_i;
                    end
                    if (start_q) begin
                        x     <= sx;
                        y     <= sy;
                        z     <= sz;
                        wcnt  <= '0;
                        state <= (Discard > 0) ? WARMUP : RUN;
                    end
                end
                WARMUP: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else begin
                        x    <= x_n;
                        y    <= y_n;
                        z    <= z_n;
                        wcnt <= wcnt + 8'd1;
                        if (wcnt == 8'(Discard - 1))
                            state <= RUN;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                    end else if (!valid_o || ready_i) begin
                        x       <= x_n;
                        y       <= y_n;
                        z       <= z_n;
                        rand_o  <= rand_n;
                        valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwl_chaos_rng.sv
// Directed bench for pwl_chaos_rng: Discard=0 and Discard=16 instances.
// Hand vectors plus a small fixed-point model of the iteration.
module tb_pwl_chaos_rng;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, seed_we, ready;
    logic [15:0] sx, sy, sz;
    logic [7:0]  rand0, rand16;
    logic        valid0, valid16, busy0, busy16;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic signed [15:0] mx, my, mz;
    logic [7:0] ref0 [1:40];
    logic [7:0] refw [1:8];
    logic       rdy_edge, vld_edge;
    logic       flag;
    int         n0;

    always #5 clk = ~clk;

    pwl_chaos_rng #(.Discard(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stop_i(stop),
        .seed_we_i(seed_we), .seed_x_i(sx), .seed_y_i(sy), .seed_z_i(sz),
        .rand_o(rand0), .valid_o(valid0), .ready_i(ready), .busy_o(busy0)
    );

    pwl_chaos_rng #(.Discard(16)) dut16 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stop_i(stop),
        .seed_we_i(seed_we), .seed_x_i(sx), .seed_y_i(sy), .seed_z_i(sz),
        .rand_o(rand16), .valid_o(valid16), .ready_i(ready), .busy_o(busy16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_step(output logic [7:0] r);
        logic signed [15:0] ax, maz, mdz, nx, ny, nz;
        logic signed [31:0] p;
        ax  = mx[15] ? -mx : mx;
        p   = mz * 16'sh1000;
        maz = p[28:13];
        mdz = ax - 16'sh2000 - my - maz;
        nx  = mx + (my >>> 6);
        ny  = my + (mz >>> 6);
        nz  = mz + (mdz >>> 6);
        mx  = nx;
        my  = ny;
        mz  = nz;
        r   = nx[7:0] ^ ny[7:0] ^ nz[7:0];
    endtask

    task automatic tick();
        rdy_edge = ready;
        vld_edge = valid0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mx = 0; my = 0; mz = 0;
        for (int i = 1; i <= 40; i++) m_step(ref0[i]);
        mx = 16'sh7FFF; my = 16'sh7FFF; mz = 0;
        for (int i = 1; i <= 8; i++) m_step(refw[i]);

        rst_n = 1'b0; start = 0; stop = 0; seed_we = 0; ready = 1;
        sx = 0; sy = 0; sz = 0;
        #3;
        chk("rst_valid", {31'd0, valid0}, 0);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_rand", {24'd0, rand0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Discard=0 and Discard=16 run with a 5-cycle stall after word 1
        start = 1;
        tick();
        start = 0;
        n0 = 0;
        flag = 0;
        for (int k = 1; k <= 30; k++) begin
            ready = !(k >= 3 && k <= 7);
            tick();
            if (k >= 2 && (!vld_edge || rdy_edge)) n0++;
            chk("run0_valid", {31'd0, valid0}, (k >= 2) ? 1 : 0);
            if (k >= 2) chk("run0_word", {24'd0, rand0}, {24'd0, ref0[n0]});
            if (k == 1) chk("run0_busy", {31'd0, busy0}, 1);
            if (k == 1) chk("dis16_busy", {31'd0, busy16}, 1);
            if (k == 2) chk("word1", {24'd0, rand0}, 32'h80);
            if (k == 7) chk("stall_hold", {24'd0, rand0}, 32'h80);
            if (k == 8) chk("word2", {24'd0, rand0}, 32'hFF);
            if (k <= 17) flag = flag | valid16;
            if (k == 17) chk("dis16_quiet", {31'd0, flag}, 0);
            if (k == 18) begin
                chk("dis16_valid", {31'd0, valid16}, 1);
                chk("dis16_word", {24'd0, rand16}, {24'd0, ref0[17]});
            end
        end

        // stop and start together: stop wins, state retained
        stop = 1; start = 1;
        tick();
        stop = 0; start = 0;
        chk("stop_busy", {31'd0, busy0}, 0);
        chk("stop_valid", {31'd0, valid0}, 0);
        chk("stop_rand", {24'd0, rand0}, {24'd0, ref0[n0]});
        tick();
        tick();
        chk("idle_hold", {24'd0, rand0}, {24'd0, ref0[n0]});
        chk("idle_busy", {31'd0, busy0}, 0);

        // seed write while running must be ignored
        start = 1;
        tick();
        start = 0;
        tick();
        sx = 16'h1234; sy = 16'h5678; sz = 16'h9ABC; seed_we = 1;
        tick();
        seed_we = 0;
        chk("restart_w1", {24'd0, rand0}, {24'd0, ref0[1]});
        stop = 1;
        tick();
        stop = 0;
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("run_seed_ignored", {24'd0, rand0}, {24'd0, ref0[1]});
        tick();
        chk("run_seed_ign_w2", {24'd0, rand0}, {24'd0, ref0[2]});
        stop = 1;
        tick();
        stop = 0;

        // seed write with start in idle, wrap-around seeds
        sx = 16'h7FFF; sy = 16'h7FFF; sz = 16'h0000;
        seed_we = 1; start = 1;
        tick();
        seed_we = 0; start = 0;
        tick();
        tick();
        chk("wrap_word", {24'd0, rand0}, 32'h81);
        chk("wrap_x", {16'd0, dut0.x}, 32'h81FE);
        chk("wrap_model_w1", {24'd0, rand0}, {24'd0, refw[1]});
        for (int j = 2; j <= 6; j++) begin
            tick();
            chk("wrap_seq", {24'd0, rand0}, {24'd0, refw[j]});
        end

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #2;
        chk("arst_valid", {31'd0, valid0}, 0);
        chk("arst_busy", {31'd0, busy0}, 0);
        chk("arst_rand", {24'd0, rand0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            flag = flag | valid0 | busy0;
        end
        chk("arst_quiet", {31'd0, flag}, 0);
        start = 1;
        tick();
        start = 0;
        tick();
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk("arst_seed_seq", {24'd0, rand0}, {24'd0, ref0[j]});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
